// File: rtl/mem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM encodings, owner ids
// and default bus widths.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 64;
    localparam int unsigned DATA_W_DEF       = 64;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWNER_1 = 1'b0;
    localparam logic OWNER_2 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the data memory
// (slave); one access in flight, completed by mem_ready.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_addr, mem_write, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_addr, mem_write, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter: MEM-stage port 1 has priority, fetch
// port 2 is forced through after STARVE_LIMIT consecutive port-1 grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic              write_1,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic              req_2,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic              write_2,
    input  logic [DATA_W-1:0] wdata_2,
    output logic              ready_1,
    output logic              ready_2,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] rdata_2,
    output logic              stall,
    mem_arbiter_if.master     mem
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              grant_2;
    logic              owner;
    logic [CNT_W-1:0]  starve_cnt;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_write_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant decision
    always_comb begin
        state_nxt = state;
        grant_2   = 1'b0;
        case (state)
            IDLE: begin
                if (req_1 || req_2) begin
                    state_nxt = BUSY;
                    grant_2   = !req_1 || (req_2 && (starve_cnt == CNT_MAX));
                end
            end
            BUSY: begin
                if (mem.mem_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, starvation counter, completion pulse and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWNER_1;
            starve_cnt  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            ready_1     <= 1'b0;
            ready_2     <= 1'b0;
            rdata_1     <= '0;
            rdata_2     <= '0;
        end else begin
            ready_1 <= 1'b0;
            ready_2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_1 || req_2) begin
                        owner       <= grant_2 ? OWNER_2 : OWNER_1;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= grant_2 ? addr_2  : addr_1;
                        mem_write_q <= grant_2 ? write_2 : write_1;
                        mem_wdata_q <= grant_2 ? wdata_2 : wdata_1;
                        // Only a port-1 grant that bypasses a waiting port 2 counts
                        if (!grant_2 && req_2) begin
                            if (starve_cnt != CNT_MAX) begin
                                starve_cnt <= starve_cnt + CNT_W'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem.mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (owner == OWNER_1) begin
                            ready_1 <= 1'b1;
                            if (!mem_write_q) begin
                                rdata_1 <= mem.mem_rdata;
                            end
                        end else begin
                            ready_2 <= 1'b1;
                            if (!mem_write_q) begin
                                rdata_2 <= mem.mem_rdata;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_write = mem_write_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign stall = (req_1 && !ready_1) || (req_2 && !ready_2);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port requester agents, a wait-state
// memory responder and an expected-completion queue checked every cycle.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned SL = 4;

    typedef struct {
        int          port;
        logic [63:0] addr;
        logic        write;
        logic [63:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_1, write_1, req_2, write_2;
    logic [AW-1:0] addr_1, addr_2;
    logic [DW-1:0] wdata_1, wdata_2;
    logic          ready_1, ready_2, stall;
    logic [DW-1:0] rdata_1, rdata_2;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .req_1(req_1), .addr_1(addr_1), .write_1(write_1), .wdata_1(wdata_1),
        .req_2(req_2), .addr_2(addr_2), .write_2(write_2), .wdata_2(wdata_2),
        .ready_1(ready_1), .ready_2(ready_2),
        .rdata_1(rdata_1), .rdata_2(rdata_2),
        .stall(stall),
        .mem(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    txn_t sb[$];
    txn_t pq1[$];
    txn_t pq2[$];
    logic [63:0] m_rd1 = '0;
    logic [63:0] m_rd2 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (a == 64'h1000) return 64'hDEADBEEF;
        return {a[31:0], ~a[31:0]};
    endfunction

    function automatic txn_t mk(input int p, input logic [63:0] a, input logic w, input logic [63:0] d);
        txn_t t;
        t.port = p; t.addr = a; t.write = w; t.wdata = d;
        return t;
    endfunction

    // Memory responder: mem_ready after mem_waits wait states of each access
    bit   auto_mem    = 1'b1;
    logic force_ready = 1'b0;
    int   mem_waits   = 0;
    int   busy_cyc    = 0;
    always @(negedge clk) begin
        if (!auto_mem) begin
            bus.mem_ready = force_ready;
            busy_cyc = 0;
        end else if (bus.mem_req) begin
            bus.mem_ready = (busy_cyc == mem_waits);
            busy_cyc++;
        end else begin
            bus.mem_ready = 1'b0;
            busy_cyc = 0;
        end
        bus.mem_rdata = mem_fn(bus.mem_addr);
    end

    // Monitor: bus contents against queue head, completions in order
    always @(posedge clk) begin
        txn_t t;
        #1;
        if (rst) begin
            m_rd1 = '0;
            m_rd2 = '0;
        end else begin
            chk("stall", 64'(stall), 64'((req_1 && !ready_1) || (req_2 && !ready_2)));
            chk("dual_ready", 64'(ready_1 && ready_2), 64'd0);
            if (bus.mem_req) begin
                if (sb.size() == 0) begin
                    chk("spurious_access", 64'(bus.mem_req), 64'd0);
                end else begin
                    chk("mem_addr", bus.mem_addr, sb[0].addr);
                    chk("mem_write", 64'(bus.mem_write), 64'(sb[0].write));
                    if (sb[0].write) chk("mem_wdata", bus.mem_wdata, sb[0].wdata);
                end
            end
            if (ready_1 || ready_2) begin
                if (sb.size() == 0) begin
                    chk("spurious_ready", 64'({ready_1, ready_2}), 64'd0);
                end else begin
                    t = sb.pop_front();
                    chk("owner", 64'(ready_2 ? 2 : 1), 64'(t.port));
                    if (!t.write) begin
                        if (t.port == 1) m_rd1 = mem_fn(t.addr);
                        else             m_rd2 = mem_fn(t.addr);
                    end
                end
            end
            chk("rdata_1", rdata_1, m_rd1);
            chk("rdata_2", rdata_2, m_rd2);
        end
    end

    task automatic drive(input txn_t t);
        if (t.port == 1) begin
            req_1 = 1'b1; addr_1 = t.addr; write_1 = t.write; wdata_1 = t.wdata;
        end else begin
            req_2 = 1'b1; addr_2 = t.addr; write_2 = t.write; wdata_2 = t.wdata;
        end
    endtask

    task automatic enqueue(input txn_t t);
        if (t.port == 1) begin
            pq1.push_back(t);
            if (pq1.size() == 1) drive(t);
        end else begin
            pq2.push_back(t);
            if (pq2.size() == 1) drive(t);
        end
    endtask

    task automatic issue(input txn_t t);
        sb.push_back(t);
        enqueue(t);
    endtask

    // One cycle; requesters move to their next transaction after ready
    task automatic cyc();
        @(negedge clk);
        if (ready_1 && pq1.size() != 0) begin
            void'(pq1.pop_front());
            if (pq1.size() != 0) drive(pq1[0]); else req_1 = 1'b0;
        end
        if (ready_2 && pq2.size() != 0) begin
            void'(pq2.pop_front());
            if (pq2.size() != 0) drive(pq2[0]); else req_2 = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((sb.size() != 0 || pq1.size() != 0 || pq2.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_pending", 64'(sb.size() + pq1.size() + pq2.size()), 64'd0);
        cyc();
        cyc();
    endtask

    task automatic measure(input int port, input int max, output int first_req,
                           output int n_wr, output int rdy_at);
        first_req = -1; n_wr = 0; rdy_at = -1;
        for (int i = 1; i <= max; i++) begin
            cyc();
            if (bus.mem_req && first_req < 0) first_req = i;
            if (bus.mem_req && bus.mem_write) n_wr++;
            if ((port == 1 ? ready_1 : ready_2) && rdy_at < 0) rdy_at = i;
        end
    endtask

    initial begin
        int fr, nw, ra;
        int order[11] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1};
        int i1, i2;
        rst = 1'b1;
        req_1 = 1'b0; addr_1 = '0; write_1 = 1'b0; wdata_1 = '0;
        req_2 = 1'b0; addr_2 = '0; write_2 = 1'b0; wdata_2 = '0;
        repeat (3) cyc();
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_ready", 64'({ready_1, ready_2}), 64'd0);
        chk("rst_rdata_1", rdata_1, 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        rst = 1'b0;
        cyc();

        // Single port-1 load, no wait states
        mem_waits = 0;
        issue(mk(1, 64'h1000, 1'b0, 64'd0));
        measure(1, 5, fr, nw, ra);
        chk("t1_first_req", 64'(fr), 64'd1);
        chk("t1_ready_at", 64'(ra), 64'd2);
        chk("t1_rdata_1", rdata_1, 64'hDEADBEEF);
        wait_done(20);

        // Port-2 store with three wait states
        mem_waits = 3;
        issue(mk(2, 64'h2008, 1'b1, 64'h55));
        measure(2, 8, fr, nw, ra);
        chk("t2_first_req", 64'(fr), 64'd1);
        chk("t2_write_cycles", 64'(nw), 64'd4);
        chk("t2_ready_at", 64'(ra), 64'd5);
        chk("t2_rdata_2", rdata_2, 64'd0);
        wait_done(20);

        // Address changes mid-access must not reach the bus
        issue(mk(1, 64'h10, 1'b0, 64'd0));
        cyc();
        cyc();
        addr_1 = 64'h20;
        wait_done(20);

        // Both ports requesting continuously: starvation release every 5th grant
        mem_waits = 0;
        i1 = 0; i2 = 0;
        for (int k = 0; k < 11; k++) begin
            if (order[k] == 1) begin
                sb.push_back(mk(1, 64'h100 + 64'(8 * i1), 1'b0, 64'd0));
                i1++;
            end else begin
                sb.push_back(mk(2, 64'h800 + 64'(8 * i2), 1'b0, 64'd0));
                i2++;
            end
        end
        for (int k = 0; k < i1; k++) enqueue(mk(1, 64'h100 + 64'(8 * k), 1'b0, 64'd0));
        for (int k = 0; k < i2; k++) enqueue(mk(2, 64'h800 + 64'(8 * k), 1'b0, 64'd0));
        cyc();
        chk("t3_stall_waiting", 64'(stall), 64'd1);
        wait_done(100);

        // mem_ready while idle is ignored
        auto_mem = 1'b0;
        force_ready = 1'b1;
        cyc();
        cyc();
        chk("t6_mem_req", 64'(bus.mem_req), 64'd0);
        chk("t6_ready", 64'({ready_1, ready_2}), 64'd0);
        force_ready = 1'b0;
        cyc();
        chk("t6_state", 64'(dut.state), 64'(IDLE));
        auto_mem = 1'b1;

        // Reset in the middle of a long access with a starvation count pending
        mem_waits = 10;
        issue(mk(1, 64'h300, 1'b0, 64'd0));
        issue(mk(2, 64'h308, 1'b0, 64'd0));
        cyc();
        cyc();
        chk("t5_busy", 64'(bus.mem_req), 64'd1);
        rst = 1'b1;
        sb.delete(); pq1.delete(); pq2.delete();
        req_1 = 1'b0; req_2 = 1'b0;
        cyc();
        chk("t5_mem_req", 64'(bus.mem_req), 64'd0);
        chk("t5_ready", 64'({ready_1, ready_2}), 64'd0);
        chk("t5_state", 64'(dut.state), 64'(IDLE));
        chk("t5_starve", 64'(dut.starve_cnt), 64'd0);
        chk("t5_rdata_1", rdata_1, 64'd0);
        chk("t5_mem_addr", bus.mem_addr, 64'd0);
        chk("t5_mem_write", 64'(bus.mem_write), 64'd0);
        rst = 1'b0;
        repeat (3) cyc();

        // Recovery after reset
        mem_waits = 1;
        issue(mk(2, 64'h400, 1'b0, 64'd0));
        wait_done(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential two-requester arbiter that shares the single-port data memory between requester 1 (MEM-stage load/store, high priority) and requester 2 (instruction fetch). It latches one request at a time, holds it on the memory bus across a variable number of wait states (mem_ready handshake), returns a one-cycle completion pulse with registered read data to the owning requester, and drives the pipeline stall line. Fixed priority for requester 1, with a starvation limit that forces a grant to requester 2.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- STARVE_LIMIT, 4, consecutive requester-1 grants while requester 2 waits before requester 2 is forced (≥1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_1 / req_2  in  1  request valid, held until the matching ready pulse
- addr_1 / addr_2  in  ADDR_W  request address, stable while req high
- write_1 / write_2  in  1  1 = store, 0 = load
- wdata_1 / wdata_2  in  DATA_W  store data
- ready_1 / ready_2  out  1  one-cycle completion pulse
- rdata_1 / rdata_2  out  DATA_W  registered load data, valid with ready, held afterwards
- mem_req  out  1  memory access valid
- mem_addr  out  ADDR_W  latched address
- mem_write  out  1  latched direction
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current access this cycle
- stall  out  1  (req_1 & ~ready_1) | (req_2 & ~ready_2), combinational

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if no req, stay. Otherwise choose owner: both requesting → 1, unless starve_cnt == STARVE_LIMIT → 2; single requester → that one. Latch addr/write/wdata and owner id into registers; → BUSY.
- BUSY: mem_req=1, mem_* driven from the latched registers only (requester inputs ignored). On mem_ready: capture mem_rdata into rdata_<owner> if load; → RESP. Otherwise stay (unbounded wait).
- RESP: ready_<owner>=1 for exactly this cycle, mem_req=0; → IDLE unconditionally.
- Requester drops or replaces its request in the cycle after ready; a req still high in the following IDLE cycle is a new request.
- Starvation counter (width clog2(STARVE_LIMIT+1)): at each IDLE grant, owner 1 with req_2 high → +1 (saturating); owner 2, or req_2 low → 0.
- Stores: rdata_<owner> not updated.
- mem_ready while not in BUSY: ignored.
- Reset values: state IDLE, mem_req 0, mem_addr/mem_wdata 0, mem_write 0, ready_1/ready_2 0, rdata_1/rdata_2 0, starve_cnt 0, latched owner 1.
- Reset mid-access (BUSY or RESP): abandon access, no ready pulse, IDLE next cycle; memory tolerates mem_req dropping without completion.

## Timing
- Request sampled in IDLE at cycle T → mem_req high from T+1.
- mem_ready at cycle T+1+W (W ≥ 0 wait states) → ready_<owner> and rdata at T+2+W.
- Minimum latency: request to ready = 2 cycles; back-to-back grants every 3 cycles plus W.
- Non-owner with req high sees stall=1 throughout; owner's stall drops only in its ready cycle.
- mem_* outputs glitch-free: all registered, constant for the whole BUSY period.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY, RESP), owner-id constants (OWNER_1, OWNER_2), default width constants.
- Single module; starvation counter and request latch inline, no sub-module.

## Test plan
- Single load on port 1, addr 0x1000, mem_ready after 0 waits with rdata 0xDEADBEEF → mem_req cycle T+1, ready_1 and rdata_1=0xDEADBEEF at T+2, ready_2 never.
- Port 2 store addr 0x2008 wdata 0x55, mem_ready after 3 waits → mem_write=1, mem_wdata=0x55 for 4 cycles, ready_2 at T+5, rdata_2 unchanged.
- req_1 and req_2 raised together, both re-requesting continuously, STARVE_LIMIT=4 → grant order 1,1,1,1,2,1,1,1,1,2; stall_2 high until its grant completes.
- Requester changes addr_1 from 0x10 to 0x20 during BUSY → mem_addr stays 0x10 until completion.
- rst asserted in BUSY with mem_ready low → next cycle IDLE, mem_req=0, no ready pulse, starve_cnt=0, all outputs at reset values.
- mem_ready pulsed in IDLE with no request → no state change, no ready, rdata unchanged.
